text_stream_player: RTL and testbench
=====================================

# text_stream_player

Parametrised ASCII message streamer for the chip's text-output path. It holds NUM_MSG fixed messages in a character ROM and plays the selected one, one character per transfer, over a valid/ready byte stream. Supported modes are one-shot or continuous loop, with abort and out-of-range select detection. It replaces the free-running, hard-coded two-message counter/decoder scheme with a handshaked, multi-message engine.

## Interface
Parameters:
- DATA_W, 8: character width (ASCII).
- NUM_MSG, 4: number of stored messages.
- SEL_W, 2: width of msg_sel; must be ≥ clog2(NUM_MSG).
- ADDR_W, 9: ROM address width; total ROM characters ≤ 2^ADDR_W.
- LEN_W, 8: width of the per-message length and of char_idx; maximum message length is 2^LEN_W−1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- msg_sel  in  SEL_W  message number, sampled only on an accepted start.
- start  in  1  single-cycle request to begin playback.
- loop_en  in  1  level input; restart the message after its last character. Sampled at each last-character handshake.
- abort  in  1  synchronous stop; highest priority after reset.
- out_data  out  DATA_W  current character.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the character.
- out_last  out  1  high with out_valid on the final character of the message.
- busy  out  1  high in any state other than IDLE.
- char_idx  out  LEN_W  index of the character currently presented (0-based).
- sel_err  out  1  one-cycle pulse when start is given with msg_sel ≥ NUM_MSG.

## Operation
- FSM states: IDLE, FETCH, SEND.
- **IDLE**
  - On start with a valid msg_sel: latch the message base address and length into cur_base/cur_len, set ptr=base and idx=0, then go to FETCH.
  - On start with msg_sel ≥ NUM_MSG: pulse sel_err and stay in IDLE.
- **FETCH**
  - Synchronous ROM read of ptr; data is available next cycle.
  - Go to SEND unconditionally.
- **SEND**
  - out_valid=1; out_data, out_last and char_idx are held stable until the handshake (out_valid & out_ready).
  - On handshake, not last: ptr+1, idx+1, go to FETCH.
  - On handshake, last character (idx==cur_len−1), loop_en=1: ptr=cur_base, idx=0, go to FETCH.
  - On handshake, last character, loop_en=0: go to IDLE.
- start while busy: ignored, no error.
- abort in any state: go to IDLE next edge and drop out_valid, even if out_ready is high in the same cycle. The aborted character counts as not transferred.
- abort and start in the same IDLE cycle: abort wins; start is ignored.
- ptr arithmetic is ADDR_W wide with no wrap inside a message; the package guarantees base+len ≤ 2^ADDR_W.
- Every message length is ≥ 1; a zero-length entry is a package elaboration error.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, char_idx=0, busy=0, sel_err=0; state IDLE.
- Start to first out_valid: 2 cycles (start edge → FETCH, FETCH edge → SEND).
- Throughput: one character per 2 cycles with out_ready held high. An N-character message completes 2N cycles after the accepted start edge.
- busy rises the cycle after an accepted start and falls the cycle after the final handshake or abort.
- sel_err is registered: high for exactly the cycle after the offending start.

## Structure
- Package text_stream_pkg contains:
  - the character ROM contents (a constant array of DATA_W entries);
  - MSG_BASE[NUM_MSG] and MSG_LEN[NUM_MSG] constants;
  - the state encoding typedef.
- Message set: msg0 "Soy de Zacapa\n" (14 chars), msg1 "OK\n" (3 chars, bench vector), msg2 and msg3 hold the production texts.
- Sub-module text_rom: synchronous single-port read ROM indexed by ADDR_W, contents from the package.
- The FSM, pointer and handshake logic stay in text_stream_player.

## Test plan
- **msg1 one-shot:** reset, msg_sel=1, start, out_ready=1 → out_data 0x4F, 0x4B, 0x0A at cycles 2, 4, 6; out_last only on 0x0A; busy low from cycle 7.
- **Backpressure:** msg1 with out_ready low for 5 cycles on the 0x4B character → out_data/char_idx=1 held stable, out_valid held high, no character lost or duplicated.
- **Loop:** msg1 with loop_en=1 for 3 passes → sequence 4F 4B 0A repeated with char_idx returning to 0; drop loop_en in pass 3 → stops after 0x0A.
- **Abort:** abort asserted on the msg0 handshake cycle of char_idx=5 → out_valid low next cycle, busy low, and a new start replays msg0 from 'S' (0x53).
- **Bad select:** NUM_MSG=3 build, msg_sel=3, start → sel_err one-cycle pulse, busy stays 0, out_valid stays 0.
- **Async reset:** assert rst_n mid-SEND between clock edges → all outputs 0 immediately; a start after release behaves as from power-up.

Source files
------------

// File: rtl/text_stream_pkg.sv
// Character ROM image, per-message base/length table and FSM encoding
// shared by the text streamer and its ROM.
package text_stream_pkg;

   localparam int PKG_NUM_MSG = 4;
   localparam int ROM_CHARS   = 29;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   localparam int MSG_BASE [PKG_NUM_MSG] = '{0, 14, 17, 23};
   localparam int MSG_LEN  [PKG_NUM_MSG] = '{14, 3, 6, 6};

   // "Soy de Zacapa\n", "OK\n", "READY\n", "ERROR\n"
   localparam logic [7:0] ROM_DATA [ROM_CHARS] = '{
      8'h53, 8'h6F, 8'h79, 8'h20, 8'h64, 8'h65, 8'h20, 8'h5A, 8'h61, 8'h63,
      8'h61, 8'h70, 8'h61, 8'h0A,
      8'h4F, 8'h4B, 8'h0A,
      8'h52, 8'h45, 8'h41, 8'h44, 8'h59, 8'h0A,
      8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0A
   };

   function automatic bit msg_table_ok(input int n, input int addr_w, input int len_w);
      msg_table_ok = (n >= 1) && (n <= PKG_NUM_MSG);
      for (int i = 0; i < PKG_NUM_MSG; i++) begin
         if (i < n && (MSG_LEN[i] < 1 ||
                       MSG_BASE[i] + MSG_LEN[i] > (1 << addr_w) ||
                       MSG_BASE[i] + MSG_LEN[i] > ROM_CHARS ||
                       MSG_LEN[i] > (1 << len_w) - 1))
            msg_table_ok = 1'b0;
      end
   endfunction

endpackage

// File: rtl/text_stream_player_rom.sv
// Synchronous-read character ROM: data appears the cycle after rd_en, then holds.
// No backpressure; the read register clears on reset so the character output idles at zero.
module text_rom
   import text_stream_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   always_comb begin
      data_d = '0;
      for (int i = 0; i < ROM_CHARS; i++) begin
         if (addr == ADDR_W'(i))
            data_d = DATA_W'(ROM_DATA[i]);
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)
         data_q <= '0;
      else if (rd_en)
         data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/text_stream_player.sv
// Plays one stored message a character at a time: start to first valid 2 cycles, 2 cycles/char.
// Each character is held on out_data until out_ready; abort drops it and returns to idle.
module text_stream_player
   import text_stream_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_MSG = 4,
   parameter int SEL_W   = 2,
   parameter int ADDR_W  = 9,
   parameter int LEN_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SEL_W-1:0]  msg_sel,
   input  logic              start,
   input  logic              loop_en,
   input  logic              abort,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic [LEN_W-1:0]  char_idx,
   output logic              sel_err
);

   if (!msg_table_ok(NUM_MSG, ADDR_W, LEN_W) || NUM_MSG > (1 << SEL_W)) begin : g_bad_cfg
      $error("text_stream_player: message table does not fit the configured parameters");
   end

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q, ptr_d, base_q, sel_base;
   logic [LEN_W-1:0]  idx_q, idx_d, len_q, sel_len;
   logic              out_valid_q, out_last_q, busy_q, sel_err_q;
   logic              sel_ok, hs, is_last;

   always_comb begin
      sel_ok   = 1'b0;
      sel_base = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_MSG; i++) begin
         if (msg_sel == SEL_W'(i)) begin
            sel_ok   = 1'b1;
            sel_base = ADDR_W'(MSG_BASE[i]);
            sel_len  = LEN_W'(MSG_LEN[i]);
         end
      end
   end

   assign hs      = out_valid_q & out_ready;
   assign is_last = (idx_q == len_q - LEN_W'(1));

   always_comb begin
      ptr_d = ptr_q;
      idx_d = idx_q;
      if (!abort) begin
         if (state_q == ST_IDLE && start && sel_ok) begin
            ptr_d = sel_base;
            idx_d = '0;
         end else if (hs) begin
            // Rewind on the last character; harmless when not looping.
            if (is_last) begin
               ptr_d = base_q;
               idx_d = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
               idx_d = idx_q + LEN_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         idx_q       <= '0;
         base_q      <= '0;
         len_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         sel_err_q <= 1'b0;
         if (abort) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     if (sel_ok) begin
                        base_q  <= sel_base;
                        len_q   <= sel_len;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                     end else begin
                        sel_err_q <= 1'b1;
                     end
                  end
               end
               ST_FETCH: begin
                  out_valid_q <= 1'b1;
                  out_last_q  <= is_last;
                  state_q     <= ST_SEND;
               end
               ST_SEND: begin
                  if (out_ready) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     if (is_last && !loop_en) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end else begin
                        state_q <= ST_FETCH;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   text_rom #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .rd_en (state_q == ST_FETCH),
      .addr  (ptr_q),
      .data  (out_data)
   );

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign char_idx  = idx_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_text_stream_player.sv
// Randomised playback bench: a string-level model of each message predicts every presented character.
module tb_text_stream_player;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] msg_sel;
   logic       start, loop_en, abort, out_ready;
   logic [7:0] out_data;
   logic       out_valid, out_last, busy, sel_err;
   logic [7:0] char_idx;

   logic [1:0] msg_sel3;
   logic       start3, loop_en3, abort3, out_ready3;
   logic [7:0] out_data3;
   logic       out_valid3, out_last3, busy3, sel_err3;
   logic [7:0] char_idx3;

   int n_tests = 0;
   int n_fail  = 0;

   string msgs [4] = '{"Soy de Zacapa\n", "OK\n", "READY\n", "ERROR\n"};

   always #5 clk = ~clk;

   text_stream_player dut (
      .clk(clk), .rst_n(rst_n), .msg_sel(msg_sel), .start(start), .loop_en(loop_en),
      .abort(abort), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .char_idx(char_idx), .sel_err(sel_err)
   );

   text_stream_player #(.NUM_MSG(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .msg_sel(msg_sel3), .start(start3), .loop_en(loop_en3),
      .abort(abort3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
      .out_last(out_last3), .busy(busy3), .char_idx(char_idx3), .sel_err(sel_err3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts message m and consumes it; each character is expected exactly two
   // cycles after the start edge or the previous transfer, then held until taken.
   task automatic play(input int m, input int passes, input int stall_pct, input int hold_pos,
                       input int hold_cycles, input int abort_pos, input bit noise);
      string      s;
      int         len, pos, pass, since, held, budget;
      bit         exp_valid, hs, done, timed_out;
      logic [7:0] exp_c;
      s = msgs[m];
      len = s.len();
      pos = 0; pass = 0; held = 0; budget = 4000; done = 0; timed_out = 0;
      msg_sel = 2'(m); start = 1'b1; loop_en = (passes > 1); out_ready = 1'b0;
      tick();
      start = 1'b0;
      since = 1;
      while (!done) begin
         exp_valid = (since >= 2);
         n_tests++;
         if (out_valid !== exp_valid || busy !== 1'b1 || sel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL play_ctrl msg%0d pos%0d: valid=%b busy=%b sel_err=%b, required valid=%b busy=1 sel_err=0",
                     m, pos, out_valid, busy, sel_err, exp_valid);
         end
         if (exp_valid) begin
            exp_c = s[pos];
            n_tests++;
            if (out_data !== exp_c || char_idx !== 8'(pos) || out_last !== (pos == len - 1)) begin
               n_fail++;
               $display("FAIL play_char msg%0d: data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                        m, out_data, char_idx, out_last, exp_c, pos, (pos == len - 1));
            end
         end
         if (exp_valid && pos == abort_pos) begin
            abort = 1'b1; out_ready = 1'b1;
            tick();
            abort = 1'b0; out_ready = 1'b0;
            n_tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_stop: valid=%b busy=%b, required 0 0", out_valid, busy);
            end
            return;
         end
         if (exp_valid && pos == hold_pos && held < hold_cycles) begin
            out_ready = 1'b0;
            held++;
         end else begin
            out_ready = ($urandom_range(99, 0) >= stall_pct);
         end
         loop_en = (pass < passes - 1);
         if (noise) begin
            start   = ($urandom_range(7, 0) == 0);
            msg_sel = 2'($urandom);
         end
         hs = exp_valid && out_ready;
         tick();
         start = 1'b0;
         since = hs ? 1 : since + 1;
         if (hs) begin
            pos++;
            if (pos == len) begin
               pos = 0;
               pass++;
               if (pass == passes) done = 1;
            end
         end
         budget--;
         if (budget == 0 && !done) begin
            n_tests++; n_fail++;
            $display("FAIL play_timeout msg%0d: pos=%0d pass=%0d, required completion", m, pos, pass);
            done = 1; timed_out = 1;
         end
      end
      out_ready = 1'b0; loop_en = 1'b0;
      if (!timed_out) begin
         n_tests++;
         if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL play_end msg%0d: busy=%b valid=%b, required 0 0", m, busy, out_valid);
         end
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 || char_idx !== 8'd0 ||
          busy !== 1'b0 || sel_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b last=%b data=%h idx=%0d busy=%b sel_err=%b, required all 0",
                  out_valid, out_last, out_data, char_idx, busy, sel_err);
      end
   endtask

   task automatic test_abort_start_same();
      abort = 1'b1; start = 1'b1; msg_sel = 2'd1;
      tick();
      abort = 1'b0; start = 1'b0;
      tick();
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || sel_err !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_beats_start: busy=%b valid=%b sel_err=%b, required 0 0 0", busy, out_valid, sel_err);
      end
   endtask

   task automatic test_bad_select();
      msg_sel3 = 2'd3; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      n_tests++;
      if (sel_err3 !== 1'b1 || busy3 !== 1'b0 || out_valid3 !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_sel_pulse: sel_err=%b busy=%b valid=%b, required 1 0 0", sel_err3, busy3, out_valid3);
      end
      repeat (3) begin
         tick();
         n_tests++;
         if (sel_err3 !== 1'b0 || busy3 !== 1'b0 || out_valid3 !== 1'b0 || out_last3 !== 1'b0 ||
             char_idx3 !== 8'd0 || out_data3 !== 8'h00) begin
            n_fail++;
            $display("FAIL bad_sel_after: sel_err=%b busy=%b valid=%b, required 0 0 0", sel_err3, busy3, out_valid3);
         end
      end
   endtask

   task automatic test_async_reset();
      msg_sel = 2'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h52) begin
         n_fail++;
         $display("FAIL areset_pre: valid=%b data=%h, required 1 52", out_valid, out_data);
      end
      #2 rst_n = 1'b1;
      #1;
      test_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      tick();
      test_reset();
      play(2, 1, 0, -1, 0, -1, 1'b0);
   endtask

   initial begin
      rst_n = 1'b1;
      msg_sel = '0; start = 1'b0; loop_en = 1'b0; abort = 1'b0; out_ready = 1'b0;
      msg_sel3 = '0; start3 = 1'b0; loop_en3 = 1'b0; abort3 = 1'b0; out_ready3 = 1'b1;
      repeat (3) tick();
      test_reset();
      #2 rst_n = 1'b0;
      tick();
      test_reset();

      play(1, 1, 0, -1, 0, -1, 1'b0);    // one-shot
      play(1, 1, 0, 1, 5, -1, 1'b0);     // backpressure on 'K'
      play(1, 3, 0, -1, 0, -1, 1'b0);    // three loop passes
      play(0, 1, 0, -1, 0, 5, 1'b0);     // abort at char 5
      play(0, 1, 0, -1, 0, -1, 1'b0);    // replay from 'S'
      test_abort_start_same();
      test_bad_select();
      test_async_reset();
      for (int i = 0; i < 12; i++)
         play(int'($urandom_range(3, 0)), int'($urandom_range(2, 1)), 40, -1, 0, -1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
